// File: rtl/axi_lite_arbiter.sv
// Two-requester arbiter onto one AXI4-Lite manager port; one transaction in flight,
// round-robin or fixed-priority grant, registered command-accept and response pulses.
module axi_lite_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_write,
    input  logic [63:0] rq_addr,
    input  logic [63:0] rq_wdata,
    input  logic [7:0]  rq_wstrb,
    output logic [1:0]  rq_ready,
    output logic [1:0]  rs_valid,
    output logic [31:0] rs_rdata,
    output logic [1:0]  rs_resp,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD} state_t;

    state_t state, state_next;

    logic        last_grant;
    logic        grant_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic [1:0]  rq_ready_q, rs_valid_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;

    logic        grant_en, grant_sel;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic        aw_done_next, w_done_next;

    always_comb begin
        // No grant in the cycle a response is being presented.
        grant_en = (state == IDLE) && (rs_valid_q == 2'b00) && (rq_valid != 2'b00);
        if (rq_valid == 2'b11) begin
            grant_sel = (RR_EN != 0) ? ~last_grant : 1'b0;
        end else begin
            grant_sel = rq_valid[1];
        end
        aw_hs        = awvalid_q & m_axi_awready;
        w_hs         = wvalid_q & m_axi_wready;
        ar_hs        = arvalid_q & m_axi_arready;
        b_hs         = bready_q & m_axi_bvalid;
        r_hs         = rready_q & m_axi_rvalid;
        aw_done_next = aw_done | aw_hs;
        w_done_next  = w_done | w_hs;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_en) state_next = rq_write[grant_sel] ? WR : RA;
            WR:   if (aw_done_next && w_done_next) state_next = WB;
            WB:   if (b_hs) state_next = IDLE;
            RA:   if (ar_hs) state_next = RD;
            RD:   if (r_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            rq_ready_q <= 2'b00;
            rs_valid_q <= 2'b00;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
        end else begin
            rq_ready_q <= 2'b00;
            rs_valid_q <= 2'b00;
            // Valids rise one cycle after the grant and fall only on their own handshake.
            aw_done    <= (state == WR) && (state_next == WR) && aw_done_next;
            w_done     <= (state == WR) && (state_next == WR) && w_done_next;
            awvalid_q  <= (state == WR) && (state_next == WR) && !aw_done_next;
            wvalid_q   <= (state == WR) && (state_next == WR) && !w_done_next;
            arvalid_q  <= (state == RA) && (state_next == RA);
            bready_q   <= (state_next == WB);
            rready_q   <= (state_next == RD);

            if (grant_en) begin
                grant_q    <= grant_sel;
                last_grant <= grant_sel;
                addr_q     <= grant_sel ? rq_addr[63:32]  : rq_addr[31:0];
                wdata_q    <= grant_sel ? rq_wdata[63:32] : rq_wdata[31:0];
                wstrb_q    <= grant_sel ? rq_wstrb[7:4]   : rq_wstrb[3:0];
                rq_ready_q[grant_sel] <= 1'b1;
            end

            if ((state == WB) && b_hs) begin
                rdata_q             <= '0;
                resp_q              <= m_axi_bresp;
                rs_valid_q[grant_q] <= 1'b1;
            end

            if ((state == RD) && r_hs) begin
                rdata_q             <= m_axi_rdata;
                resp_q              <= m_axi_rresp;
                rs_valid_q[grant_q] <= 1'b1;
            end
        end
    end

    assign rq_ready      = rq_ready_q;
    assign rs_valid      = rs_valid_q;
    assign rs_rdata      = rdata_q;
    assign rs_resp       = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: a round-robin and a fixed-priority instance share
// stimulus and a small AXI4-Lite subordinate model with programmable ready delays.
`timescale 1ns/1ps
module tb_axi_lite_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    always #5 aclk = ~aclk;

    logic [1:0]  rq_valid, rq_write;
    logic [63:0] rq_addr, rq_wdata;
    logic [7:0]  rq_wstrb;
    logic [1:0]  rq_ready, rs_valid, rs_resp;
    logic [31:0] rs_rdata;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    logic [1:0]  fp_rq_ready, fp_rs_valid, fp_rs_resp;
    logic [31:0] fp_rs_rdata, fp_awaddr, fp_wdata, fp_araddr;
    logic [3:0]  fp_wstrb;
    logic        fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;

    int tests_run = 0;
    int tests_failed = 0;

    axi_lite_arbiter #(.RR_EN(1)) dut (
        .aclk(aclk), .areset(areset),
        .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb), .rq_ready(rq_ready),
        .rs_valid(rs_valid), .rs_rdata(rs_rdata), .rs_resp(rs_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    // Fixed-priority twin: same inputs, so its handshake timing tracks the main instance.
    axi_lite_arbiter #(.RR_EN(0)) dut_fp (
        .aclk(aclk), .areset(areset),
        .rq_valid(rq_valid), .rq_write(rq_write), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb), .rq_ready(fp_rq_ready),
        .rs_valid(fp_rs_valid), .rs_rdata(fp_rs_rdata), .rs_resp(fp_rs_resp),
        .m_axi_awaddr(fp_awaddr), .m_axi_awvalid(fp_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(fp_wdata), .m_axi_wstrb(fp_wstrb), .m_axi_wvalid(fp_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(fp_bready),
        .m_axi_araddr(fp_araddr), .m_axi_arvalid(fp_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(fp_rready)
    );

    // Subordinate model, updated on falling edges; knobs set by the test tasks.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    bit          b_hold = 1'b0;
    int          b_count = 0;
    int          aw_wait, w_wait, ar_wait;
    bit          got_aw, got_w, got_ar, b_ack, r_ack;
    logic [31:0] waddr_c, wdata_c, raddr_c;
    logic [3:0]  wstrb_c;
    logic [31:0] mem [0:15];

    initial begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_ack = 0; r_ack = 0;
        waddr_c = '0; wdata_c = '0; raddr_c = '0; wstrb_c = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
                m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                got_aw = 0; got_w = 0; got_ar = 0; b_ack = 0; r_ack = 0;
            end else begin
                if (b_ack) begin m_axi_bvalid = 1'b0; b_ack = 0; b_count++; end
                if (r_ack) begin m_axi_rvalid = 1'b0; r_ack = 0; end
                if (got_aw && got_w && !m_axi_bvalid && !b_hold) begin
                    for (int i = 0; i < 4; i++)
                        if (wstrb_c[i]) mem[waddr_c[5:2]][8*i +: 8] = wdata_c[8*i +: 8];
                    m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_cfg; got_aw = 0; got_w = 0;
                end
                if (got_ar && !m_axi_rvalid) begin
                    m_axi_rvalid = 1'b1; m_axi_rdata = mem[raddr_c[5:2]];
                    m_axi_rresp = r_resp_cfg; got_ar = 0;
                end
                if (m_axi_bvalid && m_axi_bready) b_ack = 1;
                if (m_axi_rvalid && m_axi_rready) r_ack = 1;
                if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_dly); aw_wait++; end
                else begin m_axi_awready = 1'b0; aw_wait = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_dly); w_wait++; end
                else begin m_axi_wready = 1'b0; w_wait = 0; end
                if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_dly); ar_wait++; end
                else begin m_axi_arready = 1'b0; ar_wait = 0; end
                if (m_axi_awvalid && m_axi_awready) begin waddr_c = m_axi_awaddr; got_aw = 1; end
                if (m_axi_wvalid && m_axi_wready) begin wdata_c = m_axi_wdata; wstrb_c = m_axi_wstrb; got_w = 1; end
                if (m_axi_arvalid && m_axi_arready) begin raddr_c = m_axi_araddr; got_ar = 1; end
            end
        end
    end

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic drive_req(input int r, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        rq_write[r]         = wr;
        rq_addr[32*r +: 32] = a;
        rq_wdata[32*r +: 32] = d;
        rq_wstrb[4*r +: 4]  = s;
        rq_valid[r]         = 1'b1;
    endtask

    task automatic wait_rs(input int r);
        int n = 0;
        while (rs_valid[r] !== 1'b1 && n < 60) begin step(); n++; end
        tests_run++;
        if (rs_valid[r] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rs_timeout: rs_valid[%0d] still %b after %0d cycles, want 1", r, rs_valid[r], n);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1; rq_valid = 2'b00; rq_write = 2'b00;
        rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
        repeat (3) step();
        tests_run++;
        if ({rq_ready, rs_valid} !== 4'b0) begin tests_failed++;
            $display("FAIL reset_pulses: rq_ready=%b rs_valid=%b want 00 00", rq_ready, rs_valid); end
        tests_run++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin tests_failed++;
            $display("FAIL reset_axi: aw/w/ar/b/r=%b want 00000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
        tests_run++;
        if ({rs_rdata, rs_resp} !== 34'b0) begin tests_failed++;
            $display("FAIL reset_resp: rdata=%h resp=%b want 0", rs_rdata, rs_resp); end
        areset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        step();
        drive_req(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
        step();
        tests_run++;
        if (rq_ready !== 2'b01) begin tests_failed++;
            $display("FAIL wr_rq_ready: got %b want 01", rq_ready); end
        tests_run++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b00) begin tests_failed++;
            $display("FAIL wr_valid_early: aw/w=%b want 00", {m_axi_awvalid, m_axi_wvalid}); end
        rq_valid[0] = 1'b0;
        step();
        tests_run++;
        if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin tests_failed++;
            $display("FAIL wr_valid: aw/w=%b want 11", {m_axi_awvalid, m_axi_wvalid}); end
        tests_run++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {32'h4, 32'hDEADBEEF, 4'hF}) begin tests_failed++;
            $display("FAIL wr_payload: addr=%h data=%h strb=%h want 4 deadbeef f",
                     m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
        wait_rs(0);
        tests_run++;
        if ({rs_valid, rs_resp, rs_rdata, rq_ready} !== {2'b01, 2'b00, 32'h0, 2'b00}) begin tests_failed++;
            $display("FAIL wr_response: rs_valid=%b resp=%b rdata=%h rq_ready=%b want 01 00 0 00",
                     rs_valid, rs_resp, rs_rdata, rq_ready); end
        step();
        tests_run++;
        if (rs_valid !== 2'b00) begin tests_failed++;
            $display("FAIL wr_rs_pulse: rs_valid=%b one cycle later, want 00", rs_valid); end
        tests_run++;
        if (mem[1] !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL wr_memory: mem[0x4]=%h want deadbeef", mem[1]); end
    endtask

    task automatic test_write_read();
        step();
        drive_req(1, 1'b0, 32'h4, 32'h0, 4'h0);
        step();
        tests_run++;
        if (rq_ready !== 2'b10) begin tests_failed++;
            $display("FAIL rd_rq_ready: got %b want 10", rq_ready); end
        rq_valid[1] = 1'b0;
        step();
        tests_run++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_araddr} !== {1'b1, 1'b0, 32'h4}) begin tests_failed++;
            $display("FAIL rd_ar: arvalid=%b awvalid=%b araddr=%h want 1 0 4",
                     m_axi_arvalid, m_axi_awvalid, m_axi_araddr); end
        wait_rs(1);
        tests_run++;
        if ({rs_valid, rs_rdata, rs_resp} !== {2'b10, 32'hDEADBEEF, 2'b00}) begin tests_failed++;
            $display("FAIL rd_response: rs_valid=%b rdata=%h resp=%b want 10 deadbeef 00",
                     rs_valid, rs_rdata, rs_resp); end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] g [4];
        logic [1:0] gfp [4];
        logic [1:0] exp_g;
        int ng = 0;
        int n = 0;
        step();
        drive_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
        drive_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
        while (ng < 4 && n < 200) begin
            step(); n++;
            if (rq_ready != 2'b00) begin g[ng] = rq_ready; gfp[ng] = fp_rq_ready; ng++; end
        end
        rq_valid = 2'b00;
        tests_run++;
        if (ng != 4) begin tests_failed++;
            $display("FAIL rr_grant_count: got %0d grants want 4", ng); end
        for (int i = 0; i < ng; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (g[i] !== exp_g) begin tests_failed++;
                $display("FAIL rr_grant%0d: got %b want %b", i, g[i], exp_g); end
            tests_run++;
            if (gfp[i] !== 2'b01) begin tests_failed++;
                $display("FAIL fp_grant%0d: got %b want 01", i, gfp[i]); end
        end
        wait_rs(1);
        step();
    endtask

    task automatic test_skew(input int aw_d, input int w_d, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp_mem);
        int b0;
        aw_dly = aw_d; w_dly = w_d;
        b0 = b_count;
        step();
        drive_req(0, 1'b1, a, d, s);
        step();
        rq_valid[0] = 1'b0;
        step();
        tests_run++;
        if ({fp_awaddr, fp_wdata, fp_wstrb} !== {a, d, s}) begin tests_failed++;
            $display("FAIL skew_fp_payload: %h %h %h want %h %h %h", fp_awaddr, fp_wdata, fp_wstrb, a, d, s); end
        for (int k = 0; k <= 4; k++) begin
            tests_run++;
            if (m_axi_awvalid !== (k <= aw_d)) begin tests_failed++;
                $display("FAIL skew_awvalid k=%0d: got %b want %b", k, m_axi_awvalid, (k <= aw_d)); end
            tests_run++;
            if (m_axi_wvalid !== (k <= w_d)) begin tests_failed++;
                $display("FAIL skew_wvalid k=%0d: got %b want %b", k, m_axi_wvalid, (k <= w_d)); end
            tests_run++;
            if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {a, d, s}) begin tests_failed++;
                $display("FAIL skew_payload k=%0d: %h %h %h want %h %h %h",
                         k, m_axi_awaddr, m_axi_wdata, m_axi_wstrb, a, d, s); end
            if (k < 4) step();
        end
        tests_run++;
        if (m_axi_bready !== 1'b1) begin tests_failed++;
            $display("FAIL skew_bready: got %b want 1", m_axi_bready); end
        wait_rs(0);
        tests_run++;
        if ({rs_resp, rs_rdata} !== {2'b00, 32'h0}) begin tests_failed++;
            $display("FAIL skew_response: resp=%b rdata=%h want 00 0", rs_resp, rs_rdata); end
        step(); step();
        tests_run++;
        if (b_count - b0 != 1) begin tests_failed++;
            $display("FAIL skew_b_count: %0d B handshakes want 1", b_count - b0); end
        tests_run++;
        if (mem[a[5:2]] !== exp_mem) begin tests_failed++;
            $display("FAIL skew_memory: got %h want %h", mem[a[5:2]], exp_mem); end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_backpressure();
        ar_dly = 5; r_resp_cfg = 2'b10;
        step();
        drive_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        step();
        rq_valid[0] = 1'b0;
        step();
        tests_run++;
        if (fp_araddr !== 32'h8) begin tests_failed++;
            $display("FAIL bp_fp_araddr: got %h want 8", fp_araddr); end
        for (int k = 0; k <= 6; k++) begin
            tests_run++;
            if ({m_axi_arvalid, m_axi_araddr} !== {(k <= 5), 32'h8}) begin tests_failed++;
                $display("FAIL bp_ar k=%0d: arvalid=%b araddr=%h want %b 8", k, m_axi_arvalid, m_axi_araddr, (k <= 5)); end
            tests_run++;
            if (m_axi_rready !== (k == 6)) begin tests_failed++;
                $display("FAIL bp_rready k=%0d: got %b want %b", k, m_axi_rready, (k == 6)); end
            if (k < 6) step();
        end
        wait_rs(0);
        tests_run++;
        if ({rs_resp, rs_rdata} !== {2'b10, 32'h12345678}) begin tests_failed++;
            $display("FAIL bp_response: resp=%b rdata=%h want 10 12345678", rs_resp, rs_rdata); end
        tests_run++;
        if (fp_rs_resp !== 2'b10) begin tests_failed++;
            $display("FAIL bp_fp_resp: got %b want 10", fp_rs_resp); end
        ar_dly = 0; r_resp_cfg = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        b_hold = 1'b1;
        step();
        drive_req(0, 1'b1, 32'h10, 32'hCAFE0001, 4'hF);
        step();
        rq_valid[0] = 1'b0;
        while (m_axi_bready !== 1'b1 && n < 20) begin step(); n++; end
        tests_run++;
        if (m_axi_bready !== 1'b1) begin tests_failed++;
            $display("FAIL rst_reach_wb: bready=%b want 1", m_axi_bready); end
        areset = 1'b1;
        step();
        tests_run++;
        if ({rq_ready, rs_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 9'b0) begin
            tests_failed++;
            $display("FAIL rst_ctrl: rq_ready=%b rs_valid=%b aw/w/ar/b/r=%b want all 0", rq_ready, rs_valid,
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
        tests_run++;
        if ({rs_rdata, rs_resp, fp_rs_rdata, fp_rs_resp} !== 68'b0) begin tests_failed++;
            $display("FAIL rst_data: rdata=%h resp=%b fp_rdata=%h fp_resp=%b want 0",
                     rs_rdata, rs_resp, fp_rs_rdata, fp_rs_resp); end
        tests_run++;
        if ({fp_awvalid, fp_wvalid, fp_arvalid, fp_bready, fp_rready} !== 5'b0) begin tests_failed++;
            $display("FAIL rst_fp_axi: %b want 00000", {fp_awvalid, fp_wvalid, fp_arvalid, fp_bready, fp_rready}); end
        step();
        areset = 1'b0; b_hold = 1'b0;
        repeat (5) begin
            step();
            if ({rs_valid, fp_rs_valid} != 4'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++;
            $display("FAIL rst_no_response: %0d response pulses after reset want 0", seen); end
        drive_req(0, 1'b0, 32'h4, 32'h0, 4'h0);
        drive_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
        step();
        tests_run++;
        if ({rq_ready, fp_rq_ready} !== 4'b0101) begin tests_failed++;
            $display("FAIL rst_tie_grant: rq_ready=%b fp_rq_ready=%b want 01 01", rq_ready, fp_rq_ready); end
        rq_valid = 2'b00;
        wait_rs(0);
        tests_run++;
        if (rs_rdata !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL rst_after_read: rdata=%h want deadbeef", rs_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_read();
        test_round_robin();
        test_skew(3, 0, 32'h8, 32'h12345678, 4'hF, 32'h12345678);
        test_skew(0, 3, 32'hC, 32'hA5A55A5A, 4'h3, 32'h00005A5A);
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 winning.
REQ-002 SHALL have port aclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port rq_valid  in  2  per-requester command valid, bit i = requester i.
REQ-005 SHALL have port rq_write  in  2  per-requester command type, 1 = write, 0 = read.
REQ-006 SHALL have port rq_addr  in  64  requester i address at [32*i +: 32].
REQ-007 SHALL have port rq_wdata  in  64  requester i write data at [32*i +: 32].
REQ-008 SHALL have port rq_wstrb  in  8  requester i byte strobes at [4*i +: 4].
REQ-009 SHALL have port rq_ready  out  2  one-cycle pulse, command of requester i accepted.
REQ-010 SHALL have port rs_valid  out  2  one-cycle pulse, response for requester i available.
REQ-011 SHALL have port rs_rdata  out  32  read data; 0 for writes.
REQ-012 SHALL have port rs_resp  out  2  BRESP/RRESP of the completed transaction.
REQ-013 SHALL have ports m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1: AXI4-Lite write-address channel.
REQ-014 SHALL have ports m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1: write-data channel.
REQ-015 SHALL have ports m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1: write-response channel.
REQ-016 SHALL have ports m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1: read-address channel.
REQ-017 SHALL have ports m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1: read-data channel.

Function
REQ-018 SHALL register all outputs; FSM states are IDLE, WR, WB, RA and RD; at most one AXI transaction is outstanding.
REQ-019 SHALL, in IDLE with rs_valid low, grant a requester with rq_valid high:
- Only one valid: grant that one.
- Both valid, RR_EN=1: grant the requester not granted last.
- Both valid, RR_EN=0: grant requester 0.
REQ-020 SHALL, on grant g:
- Capture addr, wdata, wstrb and write of g.
- Pulse rq_ready[g] for 1 cycle.
- Update last_grant to g.
- Go to WR (write) or RA (read).
REQ-021 SHALL, in WR:
- Assert awvalid and wvalid together, starting the cycle after the grant.
- Deassert each on its own handshake (valid&&ready).
- Support simultaneous handshakes and handshakes in either order.
- Go to WB once both handshakes are done.
REQ-022 SHALL, in WB:
- Hold bready=1.
- On bvalid: capture bresp, set rdata=0, go to IDLE, and drive rs_valid[g]=1 for the next cycle.
REQ-023 SHALL, in RA:
- Assert arvalid until arready, then go to RD.
- In RD, hold rready=1.
- On rvalid: capture rdata/rresp, go to IDLE, and pulse rs_valid[g] the next cycle.
REQ-024 SHALL keep awaddr/wdata/wstrb/araddr stable while the corresponding valid is high; valids never drop before their handshake.
REQ-025 SHALL hold rs_rdata/rs_resp until the next response; rs_valid and rq_ready are never both high in the same cycle.
REQ-026 SHALL treat rq_valid dropped before grant as a withdrawn command with no side effects; requesters hold rq_* stable while rq_valid is high.
REQ-027 SHALL make the minimum latency grant-to-AXI-valid = 1 cycle and response handshake-to-rs_valid = 1 cycle; the next grant is no earlier than the cycle after rs_valid.
REQ-028 SHALL drive bready low outside WB and rready low outside RD.

Reset
REQ-029 SHALL, while areset=1, at any state including mid-transaction:
- Force the FSM to IDLE.
- Clear all m_axi valids, bready, rready, rq_ready, rs_valid, rs_rdata and rs_resp to 0.
- Set last_grant=1 so requester 0 wins the first tie.
- Abandon any in-flight transaction with no response pulse.

Verification
REQ-030 SHALL verify single write: req0 writes 0xDEADBEEF, strb 0xF, to 0x4 -> rq_ready[0] pulse, aw/w valid 1 cycle later, bresp 00 -> rs_valid[0] pulse with rs_resp=00, rs_rdata=0.
REQ-031 SHALL verify write-read: req1 reads 0x4 after the REQ-030 write -> arvalid, then rs_valid[1] with rs_rdata=0xDEADBEEF and rs_resp=00.
REQ-032 SHALL verify round-robin: both requesters hold rq_valid for 4 transactions with RR_EN=1 -> grants 0,1,0,1; with RR_EN=0 -> grants 0,0,0,0.
REQ-033 SHALL verify skewed handshakes: awready delayed 3 cycles and wready immediate, then the reverse -> each valid drops only on its own handshake; one B accepted.
REQ-034 SHALL verify back-pressure: arready held low 5 cycles -> arvalid and araddr stable for all 5 cycles; rresp=10 is forwarded on rs_resp.
REQ-035 SHALL verify reset mid-transaction: areset asserted in WB -> all outputs 0 next cycle, no rs_valid, and the next tie grants requester 0.
